// File: rtl/ft_recovery_ctrl_if.sv
// Signal bundle between the SoC fetch/reset logic and the rollback-recovery sequencer.
// The master side is the SoC plus the cores; the slave side is the sequencer.
interface ft_recovery_ctrl_if #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned NREGS     = 32,
  parameter int unsigned MAX_RETRY = 3
);
  localparam int unsigned IDX_W   = $clog2(NREGS);
  localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);

  logic                fetch_enable_i;
  logic                error_i;
  logic                commit_i;
  logic [ADDR_W-1:0]   instr_addr_i;
  logic                fetch_enable_o;
  logic                core_rst_no;
  logic [ADDR_W-1:0]   boot_addr_o;
  logic                restore_we_o;
  logic [IDX_W-1:0]    restore_addr_o;
  logic                recovering_o;
  logic [RETRY_W-1:0]  retry_cnt_o;
  logic                fatal_o;

  modport master (
    output fetch_enable_i, error_i, commit_i, instr_addr_i,
    input  fetch_enable_o, core_rst_no, boot_addr_o, restore_we_o,
    input  restore_addr_o, recovering_o, retry_cnt_o, fatal_o
  );

  modport slave (
    input  fetch_enable_i, error_i, commit_i, instr_addr_i,
    output fetch_enable_o, core_rst_no, boot_addr_o, restore_we_o,
    output restore_addr_o, recovering_o, retry_cnt_o, fatal_o
  );
endinterface

// File: rtl/ft_recovery_ctrl.sv
// Rollback-recovery sequencer for the lockstep core pair: keeps a committed-PC checkpoint,
// and on a lockstep error drains, resets the cores, replays the shadow registers, and restarts.
module ft_recovery_ctrl #(
  parameter int unsigned       ADDR_W       = 32,
  parameter int unsigned       NREGS        = 32,
  parameter int unsigned       DRAIN_CYCLES = 4,
  parameter int unsigned       RST_CYCLES   = 2,
  parameter int unsigned       MAX_RETRY    = 3,
  parameter logic [ADDR_W-1:0] BOOT_ADDR    = 32'h0000_0080
) (
  input logic               clk_i,
  input logic               rst_ni,
  ft_recovery_ctrl_if.slave bus
);

  localparam int unsigned IDX_W   = $clog2(NREGS);
  localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);
  localparam int unsigned CNT_MAX = (DRAIN_CYCLES > RST_CYCLES) ? DRAIN_CYCLES : RST_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]   DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0]   RST_LAST   = CNT_W'(RST_CYCLES - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NREGS - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_RESET   = 3'd3,
    ST_RESTORE = 3'd4,
    ST_RESUME  = 3'd5,
    ST_FATAL   = 3'd6
  } state_e;

  state_e              state_r, state_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic [IDX_W-1:0]    idx_r, idx_s;
  logic [ADDR_W-1:0]   ckpt_r, ckpt_s;
  logic [RETRY_W-1:0]  retry_r, retry_s;

  logic                run_r, run_s;
  logic                core_rst_n_r, core_rst_n_s;
  logic                restore_we_r, restore_we_s;
  logic [IDX_W-1:0]    restore_addr_r, restore_addr_s;
  logic                recovering_r, recovering_s;
  logic                fatal_r, fatal_s;

  // Next-state, counter, checkpoint and retry bookkeeping.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    idx_s   = idx_r;
    ckpt_s  = ckpt_r;
    retry_s = retry_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.fetch_enable_i) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        // An error outranks a same-cycle commit so the suspect PC never becomes the checkpoint.
        if (bus.error_i) begin
          if (retry_r == RETRY_MAX) begin
            state_s = ST_FATAL;
          end else begin
            state_s = ST_DRAIN;
            retry_s = retry_r + RETRY_W'(1);
            cnt_s   = '0;
          end
        end else if (bus.commit_i) begin
          ckpt_s  = bus.instr_addr_i;
          retry_s = '0;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (cnt_r == DRAIN_LAST) begin
          state_s = ST_RESET;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_RESET: begin
        if (cnt_r == RST_LAST) begin
          state_s = ST_RESTORE;
          cnt_s   = '0;
          idx_s   = IDX_W'(1);
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_RESTORE: begin
        if (idx_r == IDX_LAST) begin
          state_s = ST_RESUME;
          idx_s   = '0;
        end else begin
          idx_s = idx_r + IDX_W'(1);
        end
      end
      ST_RESUME: begin
        if (bus.fetch_enable_i) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FATAL: begin
        state_s = ST_FATAL;
      end
      default: begin
        state_s = ST_FATAL;
      end
    endcase
  end

  // Output decode from the upcoming state so every output leaves a flop.
  always_comb begin
    run_s          = 1'b0;
    core_rst_n_s   = 1'b1;
    restore_we_s   = 1'b0;
    restore_addr_s = '0;
    recovering_s   = 1'b0;
    fatal_s        = 1'b0;
    case (state_s)
      ST_IDLE: begin
        core_rst_n_s = 1'b1;
      end
      ST_RUN: begin
        run_s = 1'b1;
      end
      ST_DRAIN: begin
        recovering_s = 1'b1;
      end
      ST_RESET: begin
        recovering_s = 1'b1;
        core_rst_n_s = 1'b0;
      end
      ST_RESTORE: begin
        recovering_s   = 1'b1;
        restore_we_s   = 1'b1;
        restore_addr_s = idx_s;
      end
      ST_RESUME: begin
        recovering_s = 1'b1;
      end
      ST_FATAL: begin
        core_rst_n_s = 1'b0;
        fatal_s      = 1'b1;
      end
      default: begin
        core_rst_n_s = 1'b0;
        fatal_s      = 1'b1;
      end
    endcase
  end

  // Sequencer state, counters and checkpoint registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      idx_r   <= '0;
      ckpt_r  <= BOOT_ADDR;
      retry_r <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
      ckpt_r  <= ckpt_s;
      retry_r <= retry_s;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_r          <= 1'b0;
      core_rst_n_r   <= 1'b0;
      restore_we_r   <= 1'b0;
      restore_addr_r <= '0;
      recovering_r   <= 1'b0;
      fatal_r        <= 1'b0;
    end else begin
      run_r          <= run_s;
      core_rst_n_r   <= core_rst_n_s;
      restore_we_r   <= restore_we_s;
      restore_addr_r <= restore_addr_s;
      recovering_r   <= recovering_s;
      fatal_r        <= fatal_s;
    end
  end

  // In RUN the SoC enable passes straight through so a fetch stop is not delayed a cycle.
  assign bus.fetch_enable_o = run_r & bus.fetch_enable_i;
  assign bus.core_rst_no    = core_rst_n_r;
  assign bus.boot_addr_o    = ckpt_r;
  assign bus.restore_we_o   = restore_we_r;
  assign bus.restore_addr_o = restore_addr_r;
  assign bus.recovering_o   = recovering_r;
  assign bus.retry_cnt_o    = retry_r;
  assign bus.fatal_o        = fatal_r;

endmodule

// File: tb/tb_ft_recovery_ctrl.sv
// Bench for ft_recovery_ctrl: directed recovery scenarios plus random traffic,
// checked every cycle against a timeline-based reference model.
module tb_ft_recovery_ctrl;

  localparam int D       = 4;
  localparam int R       = 2;
  localparam int N       = 32;
  localparam int MR      = 3;
  localparam int REC_LEN = D + R + N;   // offset of the resume cycle after the error edge

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_REC   = 2;
  localparam int M_FATAL = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ft_recovery_ctrl_if #(.ADDR_W(32), .NREGS(N), .MAX_RETRY(MR)) bus ();

  ft_recovery_ctrl #(
    .ADDR_W(32), .NREGS(N), .DRAIN_CYCLES(D), .RST_CYCLES(R),
    .MAX_RETRY(MR), .BOOT_ADDR(32'h0000_0080)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: mode plus cycles elapsed since the error edge
  int          m_mode  = M_IDLE;
  int          m_t     = 0;
  logic [31:0] m_ckpt  = 32'h0000_0080;
  int          m_retry = 0;

  int fe_lo_cnt  = 0;
  int rst_lo_cnt = 0;
  int we_cnt     = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
  endtask

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_t     = 0;
    m_ckpt  = 32'h0000_0080;
    m_retry = 0;
  endtask

  task automatic model_edge(input logic fe, input logic err, input logic com, input logic [31:0] pc);
    if (m_mode == M_IDLE) begin
      if (fe) m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (err) begin
        if (m_retry == MR) m_mode = M_FATAL;
        else begin
          m_retry++;
          m_mode = M_REC;
          m_t    = 1;
        end
      end else if (com) begin
        m_ckpt  = pc;
        m_retry = 0;
      end
    end else if (m_mode == M_REC) begin
      if (m_t == REC_LEN) m_mode = fe ? M_RUN : M_IDLE;
      else m_t++;
    end
  endtask

  task automatic compare_all();
    bit we, in_rst, crst;
    int addr;
    we     = (m_mode == M_REC) && (m_t >= D + R + 1) && (m_t <= D + R + N - 1);
    addr   = we ? (m_t - D - R) : 0;
    in_rst = (m_mode == M_REC) && (m_t >= D + 1) && (m_t <= D + R);
    crst   = (m_mode != M_FATAL) && !in_rst && rst_n;
    check_eq("fetch_enable_o", 32'(bus.fetch_enable_o),
             32'((m_mode == M_RUN) && bus.fetch_enable_i && rst_n));
    check_eq("core_rst_no",    32'(bus.core_rst_no),    32'(crst));
    check_eq("boot_addr_o",    bus.boot_addr_o,         m_ckpt);
    check_eq("restore_we_o",   32'(bus.restore_we_o),   32'(we));
    check_eq("restore_addr_o", 32'(bus.restore_addr_o), 32'(addr));
    check_eq("recovering_o",   32'(bus.recovering_o),   32'(m_mode == M_REC));
    check_eq("retry_cnt_o",    32'(bus.retry_cnt_o),    32'(m_retry));
    check_eq("fatal_o",        32'(bus.fatal_o),        32'(m_mode == M_FATAL));
  endtask

  task automatic step(input logic fe, input logic err, input logic com, input logic [31:0] pc);
    bus.fetch_enable_i = fe;
    bus.error_i        = err;
    bus.commit_i       = com;
    bus.instr_addr_i   = pc;
    @(posedge clk);
    model_edge(fe, err, com, pc);
    #1;
    compare_all();
    if (!bus.fetch_enable_o) fe_lo_cnt++;
    if (!bus.core_rst_no)    rst_lo_cnt++;
    if (bus.restore_we_o)    we_cnt++;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.fetch_enable_i = 1'b0;
    bus.error_i        = 1'b0;
    bus.commit_i       = 1'b0;
    bus.instr_addr_i   = 32'h0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_run();
    for (int i = 0; i < 60 && m_mode != M_RUN; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    check_eq("back_to_run", 32'(bus.fetch_enable_o), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.fetch_enable_i = 1'b0;
    bus.error_i        = 1'b0;
    bus.commit_i       = 1'b0;
    bus.instr_addr_i   = 32'h0;

    // 1. start-up
    apply_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check_eq("t1_fetch_en", 32'(bus.fetch_enable_o), 32'd1);
    check_eq("t1_core_rst", 32'(bus.core_rst_no), 32'd1);
    check_eq("t1_boot",     bus.boot_addr_o, 32'h80);

    // 2. normal recovery with a two-cycle error pulse
    step(1'b1, 1'b0, 1'b1, 32'h80);
    step(1'b1, 1'b0, 1'b1, 32'h84);
    fe_lo_cnt = 0; rst_lo_cnt = 0; we_cnt = 0;
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 60 && !bus.fetch_enable_o; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    check_eq("t2_fe_low_cycles",  32'(fe_lo_cnt),  32'd38);
    check_eq("t2_rst_low_cycles", 32'(rst_lo_cnt), 32'd2);
    check_eq("t2_restore_writes", 32'(we_cnt),     32'd31);
    check_eq("t2_boot",           bus.boot_addr_o, 32'h84);
    check_eq("t2_retry_one",      32'(bus.retry_cnt_o), 32'd1);
    step(1'b1, 1'b0, 1'b1, 32'h84);
    check_eq("t2_retry_cleared",  32'(bus.retry_cnt_o), 32'd0);

    // 3. error and commit in the same cycle
    step(1'b1, 1'b1, 1'b1, 32'h88);
    check_eq("t3_boot_kept",  bus.boot_addr_o, 32'h84);
    check_eq("t3_recovering", 32'(bus.recovering_o), 32'd1);
    wait_run();

    // 4. retries exhausted
    apply_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      if (k < 3) wait_run();
    end
    check_eq("t4_fatal",    32'(bus.fatal_o), 32'd1);
    check_eq("t4_core_rst", 32'(bus.core_rst_no), 32'd0);
    check_eq("t4_retry",    32'(bus.retry_cnt_o), 32'd3);
    for (int i = 0; i < 6; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b1, 32'h100);
    check_eq("t4_fatal_held", 32'(bus.fatal_o), 32'd1);

    // 5. reset asserted in the middle of the register replay
    apply_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 32'h90);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 40 && !(m_mode == M_REC && m_t == D + R + 10); i++)
      step(1'b1, 1'b0, 1'b0, 32'h0);
    check_eq("t5_addr_before", 32'(bus.restore_addr_o), 32'd10);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("t5_we_in_reset",   32'(bus.restore_we_o),   32'd0);
    check_eq("t5_addr_in_reset", 32'(bus.restore_addr_o), 32'd0);
    compare_all();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check_eq("t5_boot_after", bus.boot_addr_o, 32'h80);

    // 6. fetch enable withdrawn while the cores are held in reset
    we_cnt = 0;
    step(1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 10 && m_t != D + 1; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 60 && m_mode == M_REC; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("t6_restore_writes", 32'(we_cnt), 32'd31);
    check_eq("t6_idle_fetch",     32'(bus.fetch_enable_o), 32'd0);
    check_eq("t6_idle_core_rst",  32'(bus.core_rst_no), 32'd1);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check_eq("t6_rerun", 32'(bus.fetch_enable_o), 32'd1);

    // random traffic
    apply_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 399) == 0) apply_reset();
      step(1'($urandom_range(0, 19) != 0),
           1'($urandom_range(0, 24) == 0),
           1'($urandom_range(0, 2) == 0),
           $urandom() & 32'hFFFF_FFFC);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
